// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the add/subtract sequencer: slice width, FSM encoding, index sizing.
// The optional ADD_SEQ_BACK2BACK_EN build macro is consumed by add_seq_ctrl.sv.
package add_seq_ctrl_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Slice index width: clog2(nslice), but never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_rca_16.sv
// 16-bit ripple-carry adder slice shared by every pass of the sequencer.
// Reports carry-out and signed overflow of its top bit.
module rca_16
    import add_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               ovf
);

    logic [SLICE_W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[SLICE_W];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf  = carry[SLICE_W] ^ carry[SLICE_W - 1];

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract sequencer over one shared 16-bit adder, LSB slice first.
// Define ADD_SEQ_BACK2BACK_EN to let a new op be accepted on the result handoff cycle.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_e           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;

    logic [31:0]        slice_lo;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_ovf;
    logic               accept;
    logic               handoff;

`ifdef ADD_SEQ_BACK2BACK_EN
    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
`else
    assign in_ready = (state == S_IDLE);
`endif

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

    assign slice_lo = SLICE_W * 32'(idx_q);
    assign slice_a  = a_q[slice_lo +: SLICE_W];
    assign slice_b  = b_q[slice_lo +: SLICE_W];

    rca_16 u_rca (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .ovf  (slice_ovf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        // Subtract is A + ~B + 1: invert B here, inject the 1 as carry-in.
                        a_q     <= in_a;
                        b_q     <= in_b ^ {WIDTH{in_sub}};
                        carry_q <= in_sub;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    out_sum[slice_lo +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        out_cout  <= slice_cout;
                        out_ovf   <= slice_ovf;
                        out_valid <= 1'b1;
                        idx_q     <= '0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (handoff) begin
                        out_valid <= 1'b0;
                        // accept can only be set here when back-to-back issue is built in.
                        if (accept) begin
                            a_q     <= in_a;
                            b_q     <= in_b ^ {WIDTH{in_sub}};
                            carry_q <= in_sub;
                            idx_q   <= '0;
                            state   <= S_RUN;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (WIDTH=32): directed cases plus randomized traffic
// against a transaction-level model; honours ADD_SEQ_BACK2BACK_EN when defined.
module tb_add_seq_ctrl;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NSLICE = WIDTH / 16;
`ifdef ADD_SEQ_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    add_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    // Reference arithmetic on a WIDTH+1-bit integer.
    function automatic res_t ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic sub);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bb;
        res_t             r;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + (WIDTH + 1)'(sub);
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction model: one op in flight, visible NSLICE+1 cycles after its handshake cycle.
    bit   m_known   = 1'b0;
    bit   m_pending = 1'b0;
    bit   m_zero    = 1'b0;
    int   m_wait    = 0;
    res_t m_res;

    always @(negedge clock) begin
        logic exp_valid;
        logic exp_ready;
        logic hand;
        logic acc;
        exp_valid = m_pending && (m_wait == 0);
        exp_ready = !m_pending || (B2B && exp_valid && out_ready);
        if (m_known) begin
            check_bit("in_ready", in_ready, exp_ready);
            check_bit("out_valid", out_valid, exp_valid);
            check_bit("busy", busy, m_pending);
            if (exp_valid) begin
                check_val("out_sum", out_sum, m_res.sum);
                check_bit("out_cout", out_cout, m_res.cout);
                check_bit("out_ovf", out_ovf, m_res.ovf);
            end
            if (m_zero) begin
                check_val("reset_sum", out_sum, 32'h0);
                check_bit("reset_cout", out_cout, 1'b0);
                check_bit("reset_ovf", out_ovf, 1'b0);
            end
        end
        if (reset) begin
            m_known   = 1'b1;
            m_pending = 1'b0;
            m_zero    = 1'b1;
            m_wait    = 0;
        end else if (m_known) begin
            hand = exp_valid && out_ready;
            acc  = in_valid && exp_ready;
            if (m_pending && m_wait > 0) m_wait--;
            if (hand) m_pending = 1'b0;
            if (acc) begin
                m_pending = 1'b1;
                m_wait    = NSLICE;
                m_res     = ref_op(in_a, in_b, in_sub);
                m_zero    = 1'b0;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output int acc);
        bit done;
        done     = 1'b0;
        acc      = cyc;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (in_ready) begin
                done = 1'b1;
                acc  = cyc;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check_bit("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (out_valid) got = 1'b1;
        end
        if (!got) check_bit("result_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] esum, input logic ecout, input logic eovf);
        int acc;
        bit got;
        out_ready = 1'b1;
        send(a, b, sub, acc);
        wait_valid(got);
        if (got) begin
            check_val("latency", 32'(cyc - acc), 32'd3);
            check_val("dir_sum", out_sum, esum);
            check_bit("dir_cout", out_cout, ecout);
            check_bit("dir_ovf", out_ovf, eovf);
        end
        @(posedge clock);
        #1;
    endtask

    logic [31:0] corner [7] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                               32'h0000FFFF, 32'hFFFF0000};

    initial begin
        int          acc;
        bit          got;
        logic [31:0] held;
        int          n_acc;
        int          n_out;
        int          acc_cyc [2];
        int          out_cyc [2];
        logic [31:0] out_s [2];
        bit          acc_now;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_bit("por_in_ready", in_ready, 1'b1);
        check_bit("por_out_valid", out_valid, 1'b0);
        check_bit("por_busy", busy, 1'b0);
        check_val("por_sum", out_sum, 32'h0);
        @(posedge clock);
        #1;

        run_op(32'h0000FFFF, 32'h1, 1'b0, 32'h00010000, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op(32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op(32'h5, 32'h7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op(32'h7, 32'h5, 1'b1, 32'h00000002, 1'b1, 1'b0);
        run_op(32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        // Stall in DONE with a competing request held high.
        out_ready = 1'b0;
        send(32'h12345678, 32'h0F0F0F0F, 1'b0, acc);
        wait_valid(got);
        @(posedge clock);
        #1;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h1;
        in_valid = 1'b1;
        held     = 32'h21436587;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_val("stall_sum", out_sum, held);
            check_bit("stall_cout", out_cout, 1'b0);
            check_bit("stall_valid", out_valid, 1'b1);
            check_bit("stall_busy", busy, 1'b1);
            check_bit("stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;

        // Reset during the first RUN cycle discards the op.
        send(32'h0000FFFF, 32'h1, 1'b0, acc);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_val("rst_sum", out_sum, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check_bit("rst_no_result", out_valid, 1'b0);
        end
        @(posedge clock);
        #1;
        run_op(32'h3, 32'h4, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);

        // Two ops with in_valid and out_ready held high.
        n_acc     = 0;
        n_out     = 0;
        acc_cyc   = '{0, 0};
        out_cyc   = '{0, 0};
        out_s     = '{32'h0, 32'h0};
        in_a      = 32'h1;
        in_b      = 32'h2;
        in_sub    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                if (n_out < 2) begin
                    out_cyc[n_out] = cyc;
                    out_s[n_out]   = out_sum;
                end
                n_out++;
            end
            if (acc_now) begin
                if (n_acc < 2) acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(posedge clock);
            #1;
            if (acc_now && n_acc == 1) begin
                in_a   = 32'h10;
                in_b   = 32'h1;
                in_sub = 1'b1;
            end
            if (acc_now && n_acc == 2) in_valid = 1'b0;
        end
        check_val("pair_results", 32'(n_out), 32'd2);
        check_val("pair_first", out_s[0], 32'h3);
        check_val("pair_second", out_s[1], 32'hF);
        check_val("pair_spacing", 32'(out_cyc[1] - out_cyc[0]), B2B ? 32'd3 : 32'd4);
        check_val("pair_accept2", 32'(acc_cyc[1] - out_cyc[0]), B2B ? 32'd0 : 32'd1);

        // Randomized traffic, occasional resets; the model process does the checking.
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = ($urandom_range(0, 9) < 3) ? corner[$urandom_range(0, 6)] : $urandom;
            in_b      = ($urandom_range(0, 9) < 3) ? corner[$urandom_range(0, 6)] : $urandom;
            in_sub    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 80) == 0);
            @(posedge clock);
            #1;
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clock);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
